// File: rtl/alu_issue.sv
// Serialized single-issue controller around an external combinational ALU.
// Owns a 16x32 register file; each legal instruction takes IDLE -> EXEC -> WB.
package alu_pkg;
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLT  = 4'd5,
    SLTU = 4'd6,
    SLL  = 4'd7,
    SRL  = 4'd8,
    SRA  = 4'd9
  } Op;

  typedef logic [31:0] UbitData;
endpackage

module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_instr,
  output Op                   alu_op,
  output UbitData             alu_a,
  output UbitData             alu_b,
  input  UbitData             alu_x,
  output logic                wr_valid,
  output logic [3:0]          wr_addr,
  output UbitData             wr_data,
  output logic                err,
  output logic [RETIRE_W-1:0] retired,
  input  logic [3:0]          dbg_addr,
  output UbitData             dbg_data
);

  localparam int unsigned REG_N     = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned OPC_W     = 4;
  localparam int unsigned IMM_W     = 8;
  localparam logic [OPC_W-1:0] OPC_LDI     = 4'hF;
  localparam logic [OPC_W-1:0] OPC_ALU_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  Op                   r_op;
  Op                   w_op_nxt;
  UbitData             r_a;
  UbitData             w_a_nxt;
  UbitData             r_b;
  UbitData             w_b_nxt;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   w_rd_nxt;
  UbitData             r_result;
  logic                r_err;
  logic                w_err_nxt;
  logic                w_capture;
  logic                w_commit;
  logic [RETIRE_W-1:0] r_retired;
  UbitData             r_rf [REG_N];

  logic [OPC_W-1:0]    w_opc;
  logic [ADDR_W-1:0]   w_rd;
  logic [ADDR_W-1:0]   w_rs1;
  logic [ADDR_W-1:0]   w_rs2;
  logic [IMM_W-1:0]    w_imm;
  logic                w_is_ldi;
  logic                w_legal;
  UbitData             w_rs1_data;
  UbitData             w_rs2_data;

  // Instruction field decode and register-file read ports (r0 hardwired to zero).
  assign w_opc      = in_instr[15:12];
  assign w_rd       = in_instr[11:8];
  assign w_rs1      = in_instr[7:4];
  assign w_rs2      = in_instr[3:0];
  assign w_imm      = in_instr[7:0];
  assign w_is_ldi   = (w_opc == OPC_LDI);
  assign w_legal    = w_is_ldi || (w_opc <= OPC_ALU_MAX);
  assign w_rs1_data = (w_rs1 == ADDR_W'(0)) ? '0 : r_rf[w_rs1];
  assign w_rs2_data = (w_rs2 == ADDR_W'(0)) ? '0 : r_rf[w_rs2];

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_rd_nxt    = r_rd;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_legal) begin
            w_state_nxt = S_EXEC;
            w_rd_nxt    = w_rd;
            if (w_is_ldi) begin
              w_op_nxt = ADD;
              w_a_nxt  = '0;
              w_b_nxt  = 32'(w_imm);
            end else begin
              w_op_nxt = Op'(w_opc);
              w_a_nxt  = w_rs1_data;
              w_b_nxt  = w_rs2_data;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
        w_capture   = 1'b1;
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
        w_commit    = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_op      <= ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_rd      <= '0;
      r_result  <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_rd    <= w_rd_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_result <= alu_x;
      end
      if (w_commit) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  // Register file; an aborted instruction never reaches the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_commit && (r_rd != ADDR_W'(0))) begin
      r_rf[r_rd] <= r_result;
    end
  end

  assign in_ready = (r_state == S_IDLE);
  assign wr_valid = (r_state == S_WB);
  assign wr_addr  = r_rd;
  assign wr_data  = r_result;
  assign err      = r_err;
  assign retired  = r_retired;
  assign alu_op   = r_op;
  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign dbg_data = (dbg_addr == ADDR_W'(0)) ? '0 : r_rf[dbg_addr];

endmodule
